// File: rtl/sprite_blitter.sv
// Raster-order image blitter: walks a colour ROM address by address and emits one
// clipped, optionally colour-keyed pixel write per cycle, ROM_LAT cycles behind the address.
module sprite_blitter #(
  parameter int                  IMG_W      = 160,
  parameter int                  IMG_H      = 120,
  parameter int                  ADDR_W     = 15,
  parameter int                  COLOUR_W   = 12,
  parameter int                  ROM_LAT    = 1,
  parameter int                  SCREEN_W   = 160,
  parameter int                  SCREEN_H   = 120,
  parameter int                  USE_KEY    = 0,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = '0
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [7:0]          x0_i,
  input  logic [7:0]          y0_i,
  output logic [ADDR_W-1:0]   rom_addr_o,
  input  logic [COLOUR_W-1:0] rom_q_i,
  output logic                plot_o,
  output logic [7:0]          x_o,
  output logic [7:0]          y_o,
  output logic [COLOUR_W-1:0] colour_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int                STAGES     = ROM_LAT - 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [7:0]        COL_LAST   = 8'(IMG_W - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'(ROM_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          col_q, col_d, row_q, row_d;
  logic [7:0]          x0_q, x0_d, y0_q, y0_d;
  logic [1:0]          drain_q, drain_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = RUN;
        addr_d  = '0;
        col_d   = '0;
        row_d   = '0;
        x0_d    = x0_i;
        y0_d    = y0_i;
      end
      RUN: begin
        // col/row track addr so the screen position needs no multiply
        if (addr_q == ADDR_LAST) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 8'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = DONE;
        else                       drain_d = drain_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rom_addr_o = addr_q;
  assign busy_o     = (state_q == RUN) || (state_q == DRAIN);
  assign done_o     = (state_q == DONE);

  // Position pipeline runs alongside the ROM; 9-bit sums so off-screen wrap is clipped.
  logic [STAGES:0]      vld_pipe;
  logic [STAGES:0][8:0] sx_pipe, sy_pipe;
  logic [8:0]           sx_in, sy_in;

  assign sx_in = {1'b0, x0_q} + {1'b0, col_q};
  assign sy_in = {1'b0, y0_q} + {1'b0, row_q};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_pipe <= '0;
      sx_pipe  <= '0;
      sy_pipe  <= '0;
    end else begin
      vld_pipe[0] <= (state_q == RUN);
      sx_pipe[0]  <= sx_in;
      sy_pipe[0]  <= sy_in;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        sx_pipe[i]  <= sx_pipe[i-1];
        sy_pipe[i]  <= sy_pipe[i-1];
      end
    end
  end

  logic                on_screen, keyed;
  logic [7:0]          x_q, y_q;
  logic [COLOUR_W-1:0] colour_q;

  assign on_screen = ({1'b0, sx_pipe[STAGES]} < 10'(SCREEN_W)) &&
                     ({1'b0, sy_pipe[STAGES]} < 10'(SCREEN_H));
  assign keyed     = (USE_KEY != 0) && (rom_q_i == KEY_COLOUR);
  assign plot_o    = vld_pipe[STAGES] && on_screen && !keyed;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else if (plot_o) begin
      x_q      <= sx_pipe[STAGES][7:0];
      y_q      <= sy_pipe[STAGES][7:0];
      colour_q <= rom_q_i;
    end
  end

  assign x_o      = plot_o ? sx_pipe[STAGES][7:0] : x_q;
  assign y_o      = plot_o ? sy_pipe[STAGES][7:0] : y_q;
  assign colour_o = plot_o ? rom_q_i : colour_q;

endmodule
